// File: rtl/clk_gating_ctrl_pkg.sv
// Shared types and helpers for the clock-request controller and its idle/wake timer.
package clk_gating_ctrl_pkg;

  localparam logic [1:0] STATE_ENC_OFF  = 2'd0;
  localparam logic [1:0] STATE_ENC_WAKE = 2'd1;
  localparam logic [1:0] STATE_ENC_ON   = 2'd2;
  localparam logic [1:0] STATE_ENC_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF  = STATE_ENC_OFF,
    ST_WAKE = STATE_ENC_WAKE,
    ST_ON   = STATE_ENC_ON,
    ST_HOLD = STATE_ENC_HOLD
  } gate_state_t;

  // Width of a down-counter that must hold the larger of the two delay loads.
  function automatic int timer_width(input int wake_cyc, input int idle_cyc);
    int max_cyc;
    max_cyc = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/clk_gating_ctrl_timer.sv
// Shared loadable down-counter used for both the wake settle delay and the idle hysteresis.
module clk_gating_ctrl_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/clk_gating_ctrl.sv
// Clock-request controller: sequences one gated clock domain (OFF/WAKE/ON/HOLD) shared by N_REQ requesters.
module clk_gating_ctrl
  import clk_gating_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_CYC = 16,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              force_on_i,
  output logic [N_REQ-1:0]  ack_o,
  output logic              gate_en_o,
  output logic [1:0]        state_o,
  output logic [STAT_W-1:0] wake_cnt_o
);

  localparam int TW = timer_width(WAKE_CYC, IDLE_CYC);
  localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYC - 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(IDLE_CYC - 1);

  gate_state_t       state_r, next_state_s;
  logic              any_req_s;
  logic              tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [TW-1:0]     tmr_load_val_s;
  logic [N_REQ-1:0]  ack_r;
  logic              gate_en_r;
  logic [STAT_W-1:0] wake_cnt_r;

  assign any_req_s = (|req_i) | force_on_i;

  clk_gating_ctrl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Next-state and timer control; a request always wins over an expiring HOLD timer.
  always_comb begin
    next_state_s   = state_r;
    tmr_load_s     = 1'b0;
    tmr_dec_s      = 1'b0;
    tmr_load_val_s = {TW{1'b0}};
    case (state_r)
      ST_OFF: begin
        if (any_req_s) begin
          next_state_s   = ST_WAKE;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = WAKE_LOAD;
        end else begin
          next_state_s = ST_OFF;
        end
      end
      ST_WAKE: begin
        if (tmr_zero_s) begin
          next_state_s = ST_ON;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_ON: begin
        if (!any_req_s) begin
          next_state_s   = ST_HOLD;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = IDLE_LOAD;
        end else begin
          next_state_s = ST_ON;
        end
      end
      ST_HOLD: begin
        if (any_req_s) begin
          next_state_s = ST_ON;
        end else if (tmr_zero_s) begin
          next_state_s = ST_OFF;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        next_state_s = ST_OFF;
      end
    endcase
  end

  // State, gate enable, acks and the saturating wake statistic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_OFF;
      gate_en_r  <= 1'b0;
      ack_r      <= {N_REQ{1'b0}};
      wake_cnt_r <= {STAT_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      gate_en_r <= (next_state_s != ST_OFF);
      ack_r     <= req_i & {N_REQ{state_r == ST_ON}};
      if ((state_r == ST_OFF) && any_req_s && (wake_cnt_r != {STAT_W{1'b1}})) begin
        wake_cnt_r <= wake_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
        wake_cnt_r <= wake_cnt_r;
      end
    end
  end

  assign state_o    = state_r;
  assign gate_en_o  = gate_en_r;
  assign ack_o      = ack_r;
  assign wake_cnt_o = wake_cnt_r;

endmodule

// File: tb/tb_clk_gating_ctrl.sv
// Directed self-checking bench for clk_gating_ctrl (N_REQ=4, WAKE_CYC=4, IDLE_CYC=16, STAT_W=2).
module tb_clk_gating_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       force_on_i;
  logic [3:0] ack_o;
  logic       gate_en_o;
  logic [1:0] state_o;
  logic [1:0] wake_cnt_o;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_OFF = 2'd0, S_WAKE = 2'd1, S_ON = 2'd2, S_HOLD = 2'd3;

  clk_gating_ctrl #(.N_REQ(4), .WAKE_CYC(4), .IDLE_CYC(16), .STAT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .force_on_i (force_on_i),
    .ack_o      (ack_o),
    .gate_en_o  (gate_en_o),
    .state_o    (state_o),
    .wake_cnt_o (wake_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs set before a call are sampled at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 4'b0000; force_on_i = 1'b0;
    step(); step();
    checks++; if (state_o !== S_OFF) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, S_OFF); end
    checks++; if (gate_en_o !== 1'b0) begin errors++; $display("FAIL reset_gate: got %0b want 0", gate_en_o); end
    checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack_o); end
    checks++; if (wake_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_wcnt: got %0d want 0", wake_cnt_o); end
    rst = 1'b0;
    step();
    checks++; if (state_o !== S_OFF) begin errors++; $display("FAIL idle_off: got %0d want %0d", state_o, S_OFF); end
  endtask

  task automatic test_wake_latency();
    req_i = 4'b0001;
    step();
    checks++; if (state_o !== S_WAKE) begin errors++; $display("FAIL wake_enter: got %0d want %0d", state_o, S_WAKE); end
    checks++; if (gate_en_o !== 1'b1) begin errors++; $display("FAIL wake_gate: got %0b want 1", gate_en_o); end
    checks++; if (wake_cnt_o !== 2'd1) begin errors++; $display("FAIL wake_cnt1: got %0d want 1", wake_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (state_o !== S_WAKE || ack_o !== 4'b0000) begin errors++; $display("FAIL wake_hold%0d: state %0d ack %b want 1/0000", i, state_o, ack_o); end
    end
    step();
    checks++; if (state_o !== S_ON) begin errors++; $display("FAIL wake_on: got %0d want %0d", state_o, S_ON); end
    checks++; if (ack_o !== 4'b0000) begin errors++; $display("FAIL wake_ack_early: got %b want 0000", ack_o); end
    step();
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL wake_ack: got %b want 0001", ack_o); end
  endtask

  task automatic test_idle_hysteresis();
    req_i = 4'b0000;
    step();
    checks++; if (state_o !== S_HOLD || ack_o !== 4'b0000 || gate_en_o !== 1'b1) begin errors++; $display("FAIL hold_enter: state %0d ack %b gate %0b want 3/0000/1", state_o, ack_o, gate_en_o); end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++; if (state_o !== S_HOLD || gate_en_o !== 1'b1) begin errors++; $display("FAIL hold_cyc%0d: state %0d gate %0b want 3/1", i, state_o, gate_en_o); end
    end
    step();
    checks++; if (state_o !== S_OFF || gate_en_o !== 1'b0) begin errors++; $display("FAIL hold_expire: state %0d gate %0b want 0/0", state_o, gate_en_o); end
    // Second pass: re-request mid-HOLD returns to ON without a new wake.
    req_i = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    checks++; if (state_o !== S_ON || wake_cnt_o !== 2'd2) begin errors++; $display("FAIL rewake_on: state %0d wcnt %0d want 2/2", state_o, wake_cnt_o); end
    req_i = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    checks++; if (state_o !== S_HOLD) begin errors++; $display("FAIL hold_mid: got %0d want %0d", state_o, S_HOLD); end
    req_i = 4'b0001;
    step();
    checks++; if (state_o !== S_ON || ack_o !== 4'b0000 || wake_cnt_o !== 2'd2) begin errors++; $display("FAIL hold_reon: state %0d ack %b wcnt %0d want 2/0000/2", state_o, ack_o, wake_cnt_o); end
    step();
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL hold_reon_ack: got %b want 0001", ack_o); end
  endtask

  task automatic test_multi_req();
    req_i = 4'b0101;
    step();
    checks++; if (ack_o !== 4'b0101) begin errors++; $display("FAIL multi_0101: got %b want 0101", ack_o); end
    req_i = 4'b0111;
    step();
    checks++; if (ack_o !== 4'b0111) begin errors++; $display("FAIL multi_0111: got %b want 0111", ack_o); end
    req_i = 4'b0110;
    step();
    checks++; if (ack_o !== 4'b0110 || state_o !== S_ON) begin errors++; $display("FAIL multi_drop: ack %b state %0d want 0110/2", ack_o, state_o); end
    req_i = 4'b0000;
    for (int i = 0; i < 17; i++) step();
    checks++; if (state_o !== S_OFF) begin errors++; $display("FAIL multi_off: got %0d want %0d", state_o, S_OFF); end
  endtask

  task automatic test_abort_free();
    logic ack_seen;
    ack_seen = 1'b0;
    req_i = 4'b0001;
    step();
    req_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      ack_seen = ack_seen | (|ack_o);
      checks++; if (state_o !== S_WAKE) begin errors++; $display("FAIL abort_wake%0d: got %0d want %0d", i, state_o, S_WAKE); end
    end
    step();
    ack_seen = ack_seen | (|ack_o);
    checks++; if (state_o !== S_ON) begin errors++; $display("FAIL abort_on: got %0d want %0d", state_o, S_ON); end
    step();
    ack_seen = ack_seen | (|ack_o);
    checks++; if (state_o !== S_HOLD) begin errors++; $display("FAIL abort_hold: got %0d want %0d", state_o, S_HOLD); end
    for (int i = 0; i < 15; i++) begin
      step();
      ack_seen = ack_seen | (|ack_o);
    end
    checks++; if (state_o !== S_HOLD) begin errors++; $display("FAIL abort_hold_end: got %0d want %0d", state_o, S_HOLD); end
    step();
    checks++; if (state_o !== S_OFF || gate_en_o !== 1'b0) begin errors++; $display("FAIL abort_off: state %0d gate %0b want 0/0", state_o, gate_en_o); end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL abort_noack: got %0b want 0", ack_seen); end
  endtask

  task automatic test_reset_mid();
    req_i = 4'b0001;
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (state_o !== S_OFF || gate_en_o !== 1'b0 || ack_o !== 4'b0000 || wake_cnt_o !== 2'd0) begin errors++; $display("FAIL rst_wake: state %0d gate %0b ack %b wcnt %0d want all 0", state_o, gate_en_o, ack_o, wake_cnt_o); end
    rst = 1'b0;
    step();
    checks++; if (state_o !== S_WAKE || wake_cnt_o !== 2'd1) begin errors++; $display("FAIL rst_rewake: state %0d wcnt %0d want 1/1", state_o, wake_cnt_o); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL rst_ack: got %b want 0001", ack_o); end
    req_i = 4'b0000;
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (state_o !== S_OFF || gate_en_o !== 1'b0 || ack_o !== 4'b0000 || wake_cnt_o !== 2'd0) begin errors++; $display("FAIL rst_hold: state %0d gate %0b ack %b wcnt %0d want all 0", state_o, gate_en_o, ack_o, wake_cnt_o); end
    rst = 1'b0;
    step();
    checks++; if (state_o !== S_OFF) begin errors++; $display("FAIL rst_stay_off: got %0d want %0d", state_o, S_OFF); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    for (int n = 0; n < 5; n++) begin
      req_i = 4'b0010;
      step();
      req_i = 4'b0000;
      for (int i = 0; i < 21; i++) step();
      exp_cnt = (n >= 2) ? 2'd3 : 2'(n + 1);
      checks++; if (state_o !== S_OFF || wake_cnt_o !== exp_cnt) begin errors++; $display("FAIL sat_cycle%0d: state %0d wcnt %0d want 0/%0d", n, state_o, wake_cnt_o, exp_cnt); end
    end
  endtask

  task automatic test_force_on();
    logic bad;
    bad = 1'b0;
    force_on_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (state_o !== S_ON) begin errors++; $display("FAIL force_on: got %0d want %0d", state_o, S_ON); end
    for (int i = 0; i < 30; i++) begin
      step();
      bad = bad | (state_o !== S_ON) | (ack_o !== 4'b0000) | (gate_en_o !== 1'b1);
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL force_hold: got %0b want 0", bad); end
    checks++; if (wake_cnt_o !== 2'd3) begin errors++; $display("FAIL force_wcnt: got %0d want 3", wake_cnt_o); end
    force_on_i = 1'b0;
    step();
    checks++; if (state_o !== S_HOLD) begin errors++; $display("FAIL force_release: got %0d want %0d", state_o, S_HOLD); end
    for (int i = 0; i < 16; i++) step();
    checks++; if (state_o !== S_OFF || gate_en_o !== 1'b0) begin errors++; $display("FAIL force_off: state %0d gate %0b want 0/0", state_o, gate_en_o); end
  endtask

  initial begin
    test_reset();
    test_wake_latency();
    test_idle_hysteresis();
    test_multi_req();
    test_abort_free();
    test_reset_mid();
    test_saturation();
    test_force_on();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
